// File: rtl/sdram_bridge_pkg.sv
// Shared types for the Wishbone-to-SDRAM prefetch bridge.
package sdram_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_RD_REQ,
    ST_RD_WAIT
  } state_e;

  localparam logic CTRL_RD = 1'b0;
  localparam logic CTRL_WR = 1'b1;

endpackage

// File: rtl/prefetch_line_buf.sv
// One prefetch line: word storage, per-word valid bits and the line tag.
// Read is combinational; the write port is byte-masked.
module prefetch_line_buf
  import sdram_bridge_pkg::*;
#(
  parameter int TAG_W      = 20,
  parameter int LINE_WORDS = 8,
  localparam int OFF_W     = $clog2(LINE_WORDS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_tag,
  input  logic [TAG_W-1:0] load_tag_val,
  input  logic             invalidate,
  input  logic             wr_en,
  input  logic             wr_set_valid,
  input  logic [OFF_W-1:0] wr_off,
  input  logic [3:0]       wr_sel,
  input  logic [31:0]      wr_data,
  input  logic [TAG_W-1:0] rd_tag,
  input  logic [OFF_W-1:0] rd_off,
  output logic             hit,
  output logic [31:0]      rd_data,
  output logic [TAG_W-1:0] tag
);

  logic [31:0]           mem [LINE_WORDS];
  logic [TAG_W-1:0]      tag_reg;
  logic                  tag_valid_reg;
  logic [LINE_WORDS-1:0] word_valid_reg;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_sel[b]) mem[wr_off][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  // Invalidate is applied after the fill-valid update so a flush landing on
  // the last fill word still leaves the line empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_reg        <= '0;
      tag_valid_reg  <= 1'b0;
      word_valid_reg <= '0;
    end else if (load_tag) begin
      tag_reg        <= load_tag_val;
      tag_valid_reg  <= 1'b1;
      word_valid_reg <= '0;
    end else begin
      if (wr_en && wr_set_valid) word_valid_reg[wr_off] <= 1'b1;
      if (invalidate) begin
        tag_valid_reg  <= 1'b0;
        word_valid_reg <= '0;
      end
    end
  end

  assign hit     = tag_valid_reg && (tag_reg == rd_tag) && word_valid_reg[rd_off];
  assign rd_data = mem[rd_off];
  assign tag     = tag_reg;

endmodule

// File: rtl/sdram_wb_prefetch_bridge.sv
// Wishbone classic slave in front of the SDRAM controller, with a single
// prefetch line that serves sequential reads and absorbs write-through merges.
module sdram_wb_prefetch_bridge
  import sdram_bridge_pkg::*;
#(
  parameter int ADDR_W     = 23,
  parameter int LINE_WORDS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic [ADDR_W-1:0] ctrl_addr,
  output logic              ctrl_rw,
  output logic [31:0]       ctrl_data_in,
  output logic              ctrl_in_valid,
  input  logic              ctrl_busy,
  input  logic [31:0]       ctrl_data_out,
  input  logic              ctrl_out_valid,
  input  logic              flush_i
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int TAG_W = ADDR_W - OFF_W;
  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(LINE_WORDS - 1);

  state_e            state_reg, state_next;
  logic [ADDR_W-1:0] word_addr, rd_word, wr_addr_reg;
  logic [TAG_W-1:0]  buf_tag;
  logic [OFF_W-1:0]  fill_ptr_reg, buf_wr_off;
  logic [31:0]       wr_data_reg, dat_reg, buf_rd_data, buf_wr_data;
  logic [3:0]        wr_sel_reg, buf_wr_sel;
  logic              wr_live_reg, flush_pending_reg, ack_reg;
  logic              req, in_fill, accept, buf_hit, hit_ok, rd_hit_ack, rd_miss;
  logic              wr_start, fill_word, fill_done, wr_ack, buf_wr_en, buf_invalidate;
  logic              unused_adr;

  assign word_addr  = wbs_adr_i[ADDR_W+1:2];
  assign unused_adr = ^{wbs_adr_i[31:ADDR_W+2], wbs_adr_i[1:0]};
  assign req        = wbs_stb_i & wbs_cyc_i & ~ack_reg;
  assign in_fill    = (state_reg == ST_RD_REQ) | (state_reg == ST_RD_WAIT);
  assign accept     = ctrl_in_valid & ~ctrl_busy;

  // While a write is pending, the buffer lookup follows the latched write
  // address so the merge decision survives an aborted Wishbone cycle.
  assign rd_word    = (state_reg == ST_WR_REQ) ? wr_addr_reg : word_addr;
  assign hit_ok     = buf_hit & ~flush_pending_reg;
  assign rd_hit_ack = req & ~wbs_we_i & hit_ok & (state_reg != ST_WR_REQ);
  assign rd_miss    = (state_reg == ST_IDLE) & req & ~wbs_we_i & ~buf_hit;
  assign wr_start   = (state_reg == ST_IDLE) & req & wbs_we_i;
  assign fill_word  = (state_reg == ST_RD_WAIT) & ctrl_out_valid;
  assign fill_done  = fill_word & (fill_ptr_reg == LAST_OFF);
  assign wr_ack     = (state_reg == ST_WR_REQ) & accept & wr_live_reg & wbs_cyc_i;

  assign buf_wr_en      = fill_word | ((state_reg == ST_WR_REQ) & accept & buf_hit);
  assign buf_wr_off     = fill_word ? fill_ptr_reg  : wr_addr_reg[OFF_W-1:0];
  assign buf_wr_sel     = fill_word ? 4'hF          : wr_sel_reg;
  assign buf_wr_data    = fill_word ? ctrl_data_out : wr_data_reg;
  assign buf_invalidate = (flush_i & ~in_fill) | (fill_done & (flush_pending_reg | flush_i));

  prefetch_line_buf #(
    .TAG_W      (TAG_W),
    .LINE_WORDS (LINE_WORDS)
  ) u_line_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_tag     (rd_miss),
    .load_tag_val (word_addr[ADDR_W-1:OFF_W]),
    .invalidate   (buf_invalidate),
    .wr_en        (buf_wr_en),
    .wr_set_valid (fill_word),
    .wr_off       (buf_wr_off),
    .wr_sel       (buf_wr_sel),
    .wr_data      (buf_wr_data),
    .rd_tag       (rd_word[ADDR_W-1:OFF_W]),
    .rd_off       (rd_word[OFF_W-1:0]),
    .hit          (buf_hit),
    .rd_data      (buf_rd_data),
    .tag          (buf_tag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (wr_start)     state_next = ST_WR_REQ;
        else if (rd_miss) state_next = ST_RD_REQ;
      end
      ST_WR_REQ:  if (accept) state_next = ST_IDLE;
      ST_RD_REQ:  if (accept) state_next = ST_RD_WAIT;
      ST_RD_WAIT: if (fill_word) state_next = fill_done ? ST_IDLE : ST_RD_REQ;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ctrl_in_valid = 1'b0;
    ctrl_rw       = CTRL_RD;
    ctrl_addr     = '0;
    ctrl_data_in  = '0;
    case (state_reg)
      ST_WR_REQ: begin
        ctrl_in_valid = 1'b1;
        ctrl_rw       = CTRL_WR;
        ctrl_addr     = wr_addr_reg;
        ctrl_data_in  = wr_data_reg;
      end
      ST_RD_REQ: begin
        ctrl_in_valid = 1'b1;
        ctrl_addr     = {buf_tag, fill_ptr_reg};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_reg           <= 1'b0;
      dat_reg           <= '0;
      wr_addr_reg       <= '0;
      wr_data_reg       <= '0;
      wr_sel_reg        <= '0;
      wr_live_reg       <= 1'b0;
      fill_ptr_reg      <= '0;
      flush_pending_reg <= 1'b0;
    end else begin
      ack_reg <= rd_hit_ack | wr_ack;
      if (rd_hit_ack) dat_reg <= buf_rd_data;
      if (wr_start) begin
        wr_addr_reg <= word_addr;
        wr_data_reg <= wbs_dat_i;
        wr_sel_reg  <= wbs_sel_i;
        wr_live_reg <= 1'b1;
      end else if (!wbs_cyc_i) begin
        wr_live_reg <= 1'b0;
      end
      if (rd_miss)                    fill_ptr_reg <= '0;
      else if (fill_word && !fill_done) fill_ptr_reg <= fill_ptr_reg + 1'b1;
      if (fill_done)                            flush_pending_reg <= 1'b0;
      else if (flush_i && (in_fill || rd_miss)) flush_pending_reg <= 1'b1;
    end
  end

  assign wbs_ack_o = ack_reg;
  assign wbs_dat_o = dat_reg;

endmodule
